// File: rtl/accumulator_pkg.sv
// accumulator_pkg: shared types and helpers for the accumulator unit.
// Rev 1.0
`default_nettype none

package accumulator_pkg;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_INC  = 3'd4,
    OP_DEC  = 3'd5,
    OP_SHLN = 3'd6,
    OP_SHRN = 3'd7
  } op_t;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_SHIFTING = 1'b1
  } ctrl_state_t;

  // Requests longer than the word just empty it, so saturate at the width.
  function automatic int unsigned shift_clamp(input int unsigned amt, input int unsigned width);
    return (amt > width) ? width : amt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/acc_alu.sv
// acc_alu: combinational next-state arithmetic for the single-cycle accumulator ops.
// Rev 1.0
`default_nettype none

module acc_alu
  import accumulator_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] din,
  input  op_t              op,
  output logic [WIDTH-1:0] acc_next,
  output logic             carry_next,
  output logic             ovf_next
);

  localparam int MSB = WIDTH - 1;

  always_comb begin
    acc_next   = acc;
    carry_next = 1'b0;
    ovf_next   = 1'b0;
    case (op)
      OP_LOAD: acc_next = din;
      OP_ADD: begin
        {carry_next, acc_next} = {1'b0, acc} + {1'b0, din};
        ovf_next = (acc[MSB] == din[MSB]) && (acc_next[MSB] != acc[MSB]);
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        {carry_next, acc_next} = {1'b0, acc} - {1'b0, din};
        ovf_next = (acc[MSB] != din[MSB]) && (acc_next[MSB] != acc[MSB]);
      end
      OP_INC: begin
        {carry_next, acc_next} = {1'b0, acc} + (WIDTH + 1)'(1);
        ovf_next = (acc == {1'b0, {(WIDTH - 1){1'b1}}});
      end
      OP_DEC: begin
        acc_next   = acc - WIDTH'(1);
        carry_next = (acc == '0);
        ovf_next   = (acc == {1'b1, {(WIDTH - 1){1'b0}}});
      end
      default: begin
        acc_next   = acc;
        carry_next = 1'b0;
        ovf_next   = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/accumulator_unit.sv
// accumulator_unit: WIDTH-bit accumulator with arithmetic ops, flags and a
// Busy/Done handshake for multi-cycle logical shifts. Rev 1.0
`default_nettype none

module accumulator_unit
  import accumulator_pkg::*;
#(
  parameter int              WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int             SW          = $clog2(WIDTH + 1)
) (
  input  logic             MainClock,
  input  logic             ClearN,
  input  logic             Latch,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] Din,
  input  logic [SW-1:0]    ShAmt,
  output logic [WIDTH-1:0] Acc,
  output logic             Carry,
  output logic             Overflow,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  ctrl_state_t      state, state_next;
  logic [SW-1:0]    shift_cnt;
  logic             shift_left;
  op_t              cmd;
  logic             accept;
  logic             is_shift;
  logic [SW-1:0]    shift_k;
  logic [WIDTH-1:0] alu_acc;
  logic             alu_carry;
  logic             alu_ovf;

  assign cmd      = op_t'(Op);
  assign accept   = Latch && (state == ST_IDLE);
  assign is_shift = (cmd == OP_SHLN) || (cmd == OP_SHRN);
  assign shift_k  = SW'(shift_clamp(32'(ShAmt), WIDTH));

  assign Zero = (Acc == '0);
  assign Busy = (state == ST_SHIFTING);

  acc_alu #(.WIDTH(WIDTH)) u_alu (
    .acc        (Acc),
    .din        (Din),
    .op         (cmd),
    .acc_next   (alu_acc),
    .carry_next (alu_carry),
    .ovf_next   (alu_ovf)
  );

  always_ff @(posedge MainClock or negedge ClearN) begin
    if (!ClearN) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (accept && is_shift && (shift_k != '0)) state_next = ST_SHIFTING;
      ST_SHIFTING: if (shift_cnt == SW'(1)) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge MainClock or negedge ClearN) begin
    if (!ClearN) begin
      Acc        <= RESET_VALUE;
      Carry      <= 1'b0;
      Overflow   <= 1'b0;
      Done       <= 1'b0;
      shift_cnt  <= '0;
      shift_left <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (accept) begin
        case (cmd)
          OP_LOAD, OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
            Acc      <= alu_acc;
            Carry    <= alu_carry;
            Overflow <= alu_ovf;
            Done     <= 1'b1;
          end
          OP_SHLN, OP_SHRN: begin
            // Acc is left alone here; shifting starts on the following edge.
            shift_cnt  <= shift_k;
            shift_left <= (cmd == OP_SHLN);
            if (shift_k == '0) Done <= 1'b1;
          end
          default: Done <= 1'b1;
        endcase
      end else if (state == ST_SHIFTING) begin
        if (shift_left) begin
          Acc   <= {Acc[WIDTH-2:0], 1'b0};
          Carry <= Acc[WIDTH-1];
        end else begin
          Acc   <= {1'b0, Acc[WIDTH-1:1]};
          Carry <= Acc[0];
        end
        shift_cnt <= shift_cnt - SW'(1);
        if (shift_cnt == SW'(1)) Done <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_accumulator_unit.sv
// tb_accumulator_unit: randomized self-checking bench against an arithmetic model.
// Rev 1.0
`default_nettype none

module tb_accumulator_unit;

  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic         clk;
  logic         rst_n;
  logic         latch;
  logic [2:0]   op;
  logic [W-1:0] din;
  logic [2:0]   sh_amt;
  logic [W-1:0] acc;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         busy;
  logic         done;

  int vectors;
  int miscompares;

  int m_acc;
  int m_carry;
  int m_ovf;

  accumulator_unit #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .MainClock (clk),
    .ClearN    (rst_n),
    .Latch     (latch),
    .Op        (op),
    .Din       (din),
    .ShAmt     (sh_amt),
    .Acc       (acc),
    .Carry     (carry),
    .Overflow  (overflow),
    .Zero      (zero),
    .Busy      (busy),
    .Done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v > SMAX) ? v - (1 << W) : v;
  endfunction

  task automatic check_regs(input string tag);
    check({tag, ".acc"},   32'(acc),      32'(m_acc));
    check({tag, ".carry"}, 32'(carry),    32'(m_carry));
    check({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
    check({tag, ".zero"},  32'(zero),     32'(m_acc == 0));
  endtask

  // Applies one command, walks the model through it and checks every cycle.
  task automatic do_cmd(input int o, input int d, input int s, input bit inject);
    int k;
    int sres;
    @(negedge clk);
    latch = 1'b1; op = 3'(o); din = W'(d); sh_amt = 3'(s);
    @(posedge clk); #1;
    latch = 1'b0;
    din   = W'($urandom);
    case (o)
      1: begin m_acc = d; m_carry = 0; m_ovf = 0; end
      2: begin
        sres    = to_signed(m_acc) + to_signed(d);
        m_carry = (m_acc + d) > MASK;
        m_acc   = (m_acc + d) & MASK;
        m_ovf   = (sres > SMAX) || (sres < SMIN);
      end
      3: begin
        sres    = to_signed(m_acc) - to_signed(d);
        m_carry = m_acc < d;
        m_acc   = (m_acc - d) & MASK;
        m_ovf   = (sres > SMAX) || (sres < SMIN);
      end
      4: begin
        m_ovf   = (to_signed(m_acc) + 1) > SMAX;
        m_carry = m_acc == MASK;
        m_acc   = (m_acc + 1) & MASK;
      end
      5: begin
        m_ovf   = (to_signed(m_acc) - 1) < SMIN;
        m_carry = m_acc == 0;
        m_acc   = (m_acc - 1) & MASK;
      end
      default: ;
    endcase
    if (o < 6) begin
      check("cmd.done", 32'(done), 32'd1);
      check("cmd.busy", 32'(busy), 32'd0);
      check_regs("cmd");
    end else begin
      k = (s > W) ? W : s;
      if (k == 0) begin
        check("sh0.done", 32'(done), 32'd1);
        check("sh0.busy", 32'(busy), 32'd0);
        check_regs("sh0");
      end else begin
        check("shacc.busy", 32'(busy), 32'd1);
        check("shacc.done", 32'(done), 32'd0);
        check("shacc.acc",  32'(acc),  32'(m_acc));
        for (int i = 1; i <= k; i++) begin
          if (inject) begin
            @(negedge clk);
            latch = 1'b1; op = 3'd1; din = W'($urandom);
          end
          @(posedge clk); #1;
          latch = 1'b0;
          if (o == 6) begin
            m_carry = (m_acc >> (W - 1)) & 1;
            m_acc   = (m_acc << 1) & MASK;
          end else begin
            m_carry = m_acc & 1;
            m_acc   = m_acc >> 1;
          end
          check("sh.busy", 32'(busy), 32'(i < k));
          check("sh.done", 32'(done), 32'(i == k));
          check("sh.acc",  32'(acc),  32'(m_acc));
        end
        check_regs("shend");
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    check("idle.done", 32'(done), 32'd0);
    check("idle.busy", 32'(busy), 32'd0);
    check_regs("idle");
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; latch = 1'b0; op = '0; din = '0; sh_amt = '0;
    m_acc = 0; m_carry = 0; m_ovf = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    // Reset asserted mid-cycle after loading a non-zero value.
    do_cmd(1, 5, 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    m_acc = 0; m_carry = 0; m_ovf = 0;
    check_regs("rst");
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    idle_cycle();

    do_cmd(1, 7, 0, 0);
    do_cmd(2, 1, 0, 0);
    check("t2.acc", 32'(acc), 32'h8);
    check("t2.ovf", 32'(overflow), 32'd1);
    do_cmd(2, 15, 0, 0);
    check("t3.add", 32'({carry, overflow, acc}), 32'h37);
    do_cmd(3, 9, 0, 0);
    check("t3.sub", 32'({carry, overflow, acc}), 32'h3E);
    do_cmd(1, 0, 0, 0);
    do_cmd(5, 0, 0, 0);
    check("t3.dec", 32'({carry, overflow, acc}), 32'h2F);

    do_cmd(1, 11, 0, 0);
    do_cmd(6, 0, 3, 1);
    check("t4.shl", 32'({carry, acc}), 32'h18);
    idle_cycle();
    do_cmd(1, 9, 0, 0);
    do_cmd(7, 0, 7, 0);
    check("t5.shr", 32'({carry, zero, acc}), 32'h30);
    do_cmd(7, 0, 0, 0);
    idle_cycle();

    // Reset during the second cycle of a four-cycle shift.
    do_cmd(1, 15, 0, 0);
    @(negedge clk);
    latch = 1'b1; op = 3'd6; sh_amt = 3'd4;
    @(posedge clk); #1; latch = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    m_acc = 0; m_carry = 0; m_ovf = 0;
    check("t6.acc",  32'(acc),  32'd0);
    check("t6.busy", 32'(busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) idle_cycle();
    do_cmd(1, 6, 0, 0);

    for (int n = 0; n < 300; n++) begin
      do_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
             int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/accumulator_unit.md
Name: accumulator_unit

Overview:
- Parametrised successor to the 4-bit latch/clear operand register feeding the ALU.
- Holds a WIDTH-bit accumulator with selectable operations (load, add, sub, inc, dec, multi-cycle shift) and carry/overflow/zero flags.
- A Busy/Done handshake covers multi-cycle shifts.
- Sits between the data bus and the ALU operand inputs; Acc drives the ALU directly.

Parameters:
- WIDTH, 4: accumulator and data bus width; must be 2 or more.
- RESET_VALUE, 0: value loaded into Acc on reset.
- SW (localparam), $clog2(WIDTH+1): width of ShAmt.

Ports:
- MainClock  in  1  sole clock, rising edge.
- ClearN  in  1  asynchronous active-low reset.
- Latch  in  1  command strobe; qualifies Op for one cycle.
- Op  in  3  operation code (see Behaviour).
- Din  in  WIDTH  bus operand.
- ShAmt  in  SW  shift distance for SHLN/SHRN.
- Acc  out  WIDTH  accumulator contents, registered.
- Carry  out  1  carry/borrow/last-shifted-out bit, registered.
- Overflow  out  1  signed overflow, registered.
- Zero  out  1  combinational, equals (Acc == 0).
- Busy  out  1  multi-cycle shift in progress, registered.
- Done  out  1  one-cycle pulse when a command completes, registered.

Behaviour:
- Reset (ClearN=0, asynchronous): Acc=RESET_VALUE, Carry=0, Overflow=0, Busy=0, Done=0, shift counter=0.
  - Reset mid-shift aborts the shift; no Done is produced.
- Acceptance: a command is accepted on a rising edge only when Latch=1 and Busy=0.
  - Latch while Busy=1 is ignored and dropped, with no queueing.
  - Latch=0 means hold.
  - Done defaults to 0 on every edge unless set as described below.
- Op encoding:
  - 0 HOLD
  - 1 LOAD
  - 2 ADD
  - 3 SUB
  - 4 INC
  - 5 DEC
  - 6 SHLN
  - 7 SHRN
- Single-cycle ops update on the accepting edge and set Done=1 for the following cycle:
  - HOLD: no state change; Done still pulses.
  - LOAD: Acc=Din, Carry=0, Overflow=0.
  - ADD: {Carry,Acc}=Acc+Din. Overflow = operands have equal sign and the result sign differs.
  - SUB: Acc=Acc-Din mod 2^WIDTH. Carry=1 if Acc<Din unsigned (borrow). Overflow = operands have different sign and the result sign differs from Acc.
  - INC: {Carry,Acc}=Acc+1. Overflow=1 only on the wrap from 0111..1 to 1000..0.
  - DEC: Acc=Acc-1. Carry=1 only when Acc was 0. Overflow=1 only on the wrap from 1000..0 to 0111..1.
- SHLN/SHRN (logical, zero-fill, multi-cycle):
  - The accepting edge latches direction and count k=min(ShAmt,WIDTH) and sets Busy=1. Acc is unchanged on that edge.
  - On each of the next k edges, Acc shifts by one bit and Carry takes the bit shifted out.
  - On the k-th shift edge, Busy goes to 0 and Done goes to 1 (one cycle). Total latency is k+1 edges.
  - k=0: no Busy, Acc and Carry unchanged, Done pulses after the accepting edge.
  - Overflow is unchanged by shifts.
  - ShAmt greater than WIDTH saturates to WIDTH: Acc ends at 0 and Carry holds the last bit out.
- Zero always reflects the current Acc, including during a shift.
- All outputs except Zero are register outputs.

Decomposition:
- accumulator_pkg:
  - op_t enum (HOLD..SHRN, 3 bits)
  - function for shift-count clamp
- Sub-module acc_alu (combinational): takes Acc, Din, op_t; returns next Acc, Carry, Overflow for single-cycle ops.
- accumulator_unit holds the registers, the shift counter/direction, and the Busy/Done control: IDLE/SHIFTING, where SHIFTING is Busy=1.

Test Plan:
All cases use WIDTH=4.
1. Reset: assert ClearN=0 mid-cycle, then release -> Acc=0, Carry=0, Overflow=0, Busy=0, Done=0, Zero=1.
2. LOAD Din=0x7, then ADD Din=0x1 -> Acc=0x8, Carry=0, Overflow=1, Done pulses after each command.
3. ADD overflow, SUB and DEC:
   - ADD Din=0xF to Acc=0x8 -> Acc=0x7, Carry=1, Overflow=1.
   - SUB Din=0x9 from Acc=0x7 -> Acc=0xE, Carry=1, Overflow=1.
   - DEC from 0x0 -> Acc=0xF, Carry=1, Overflow=0.
4. SHLN with ShAmt=3 on Acc=0xB -> Busy=1 for 3 cycles, then Acc=0x8, Carry=1, Done pulses once. A Latch+LOAD issued while Busy is ignored.
5. SHRN with ShAmt=7 (saturates to 4) on Acc=0x9 -> Busy 4 cycles, then Acc=0x0, Zero=1, Carry=1. SHRN with ShAmt=0 -> Acc unchanged, Done next cycle, Busy stays 0.
6. ClearN asserted during the 2nd cycle of a 4-cycle shift -> immediately Acc=0, Busy=0; no Done follows; a new LOAD is accepted after release.
